// File: rtl/fx2_in_arbiter.sv
// Shares the FX2 IN byte stream between samples and command replies; replies win at boundaries, samples go in bounded bursts.
// 0-cycle combinational byte path; out_ack backpressure reaches only the granted source; PKTEND is requested to commit short packets.
module fx2_in_arbiter #(
  parameter int BURST_LEN    = 64,
  parameter int PKT_SIZE     = 512,
  parameter int FLUSH_CYCLES = 4096
) (
  input  logic       fx2_clk,
  input  logic       reset,
  input  logic [7:0] sample,
  input  logic       sample_rdy,
  output logic       sample_ack,
  input  logic [7:0] reply,
  input  logic       reply_rdy,
  input  logic       reply_end,
  output logic       reply_ack,
  output logic [7:0] out_data,
  output logic       out_rdy,
  input  logic       out_ack,
  output logic       out_pktend,
  input  logic       out_pktend_ack,
  output logic       busy
);

  localparam int PW = $clog2(PKT_SIZE);
  localparam int BW = $clog2(BURST_LEN + 1);
  localparam int IW = $clog2(FLUSH_CYCLES + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SAMPLE,
    ST_REPLY,
    ST_PKTEND_PRE,
    ST_PKTEND_POST,
    ST_PKTEND_IDLE
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] pkt_cnt_q, pkt_cnt_d;
  logic [BW-1:0] burst_cnt_q, burst_cnt_d;
  logic [IW-1:0] idle_cnt_q, idle_cnt_d;
  logic          last_sample_q, last_sample_d;
  logic          xfer;
  logic [PW-1:0] pkt_inc;

  // PKT_SIZE is a power of two, so the natural wrap of pkt_inc is the packet wrap.
  assign pkt_inc = pkt_cnt_q + 1'b1;

  always_comb begin
    out_rdy    = 1'b0;
    out_data   = 8'h00;
    out_pktend = 1'b0;
    case (state_q)
      ST_SAMPLE: begin
        out_rdy  = sample_rdy;
        out_data = sample;
      end
      ST_REPLY: begin
        out_rdy  = reply_rdy;
        out_data = reply;
      end
      ST_PKTEND_PRE, ST_PKTEND_POST, ST_PKTEND_IDLE: out_pktend = 1'b1;
      default: ;
    endcase
    if (reset) begin
      out_rdy    = 1'b0;
      out_pktend = 1'b0;
    end
  end

  assign xfer       = out_rdy & out_ack;
  assign sample_ack = xfer & (state_q == ST_SAMPLE);
  assign reply_ack  = xfer & (state_q == ST_REPLY);
  assign busy       = (state_q != ST_IDLE) & ~reset;

  always_comb begin
    state_d       = state_q;
    pkt_cnt_d     = xfer ? pkt_inc : pkt_cnt_q;
    burst_cnt_d   = burst_cnt_q;
    idle_cnt_d    = '0;
    last_sample_d = last_sample_q;
    case (state_q)
      ST_IDLE: begin
        if (reply_rdy) begin
          // Partial sample data must be committed before the reply lands in the packet.
          state_d       = (pkt_cnt_q != '0 && last_sample_q) ? ST_PKTEND_PRE : ST_REPLY;
          last_sample_d = 1'b0;
        end else if (sample_rdy) begin
          state_d       = ST_SAMPLE;
          burst_cnt_d   = '0;
          last_sample_d = 1'b1;
        end else if (pkt_cnt_q != '0) begin
          if (idle_cnt_q == IW'(FLUSH_CYCLES - 1)) begin
            state_d = ST_PKTEND_IDLE;
          end else begin
            idle_cnt_d = idle_cnt_q + 1'b1;
          end
        end
      end
      ST_SAMPLE: begin
        if (xfer) begin
          burst_cnt_d = burst_cnt_q + 1'b1;
          if (burst_cnt_q == BW'(BURST_LEN - 1)) begin
            state_d = ST_IDLE;
          end
        end else if (!sample_rdy) begin
          state_d = ST_IDLE;
        end
      end
      ST_REPLY: begin
        if (xfer && reply_end) begin
          state_d = (pkt_inc == '0) ? ST_IDLE : ST_PKTEND_POST;
        end
      end
      ST_PKTEND_PRE: begin
        if (out_pktend_ack) begin
          pkt_cnt_d = '0;
          state_d   = ST_REPLY;
        end
      end
      ST_PKTEND_POST, ST_PKTEND_IDLE: begin
        if (out_pktend_ack) begin
          pkt_cnt_d = '0;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge fx2_clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      pkt_cnt_q     <= '0;
      burst_cnt_q   <= '0;
      idle_cnt_q    <= '0;
      last_sample_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pkt_cnt_q     <= pkt_cnt_d;
      burst_cnt_q   <= burst_cnt_d;
      idle_cnt_q    <= idle_cnt_d;
      last_sample_q <= last_sample_d;
    end
  end

endmodule

// File: tb/tb_fx2_in_arbiter.sv
// Bench for fx2_in_arbiter: byte queues act as sources, a stream-level model tracks packet position and flush obligations.
module tb_fx2_in_arbiter;

  localparam int BURST_LEN    = 64;
  localparam int PKT_SIZE     = 512;
  localparam int FLUSH_CYCLES = 4096;

  logic       fx2_clk = 1'b0;
  logic       reset;
  logic [7:0] sample;
  logic       sample_rdy;
  logic       sample_ack;
  logic [7:0] reply;
  logic       reply_rdy;
  logic       reply_end;
  logic       reply_ack;
  logic [7:0] out_data;
  logic       out_rdy;
  logic       out_ack;
  logic       out_pktend;
  logic       out_pktend_ack;
  logic       busy;

  fx2_in_arbiter #(
    .BURST_LEN(BURST_LEN), .PKT_SIZE(PKT_SIZE), .FLUSH_CYCLES(FLUSH_CYCLES)
  ) dut (
    .fx2_clk(fx2_clk), .reset(reset),
    .sample(sample), .sample_rdy(sample_rdy), .sample_ack(sample_ack),
    .reply(reply), .reply_rdy(reply_rdy), .reply_end(reply_end), .reply_ack(reply_ack),
    .out_data(out_data), .out_rdy(out_rdy), .out_ack(out_ack),
    .out_pktend(out_pktend), .out_pktend_ack(out_pktend_ack), .busy(busy)
  );

  always #5 fx2_clk = ~fx2_clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] sq[$];     // sample bytes still to be delivered
  logic [8:0] rq[$];     // {last, byte} reply bytes still to be delivered
  int  ack_pct = 100;    // out_ack probability (percent)
  int  pk_pct  = 50;     // out_pktend_ack probability (percent)

  // Reference model state: position in the USB packet and pending commit obligations.
  int  pos = 0;
  bit  in_reply = 0;
  bit  need_flush = 0;
  int  streak = 0;
  int  n_samp = 0, n_rep = 0, n_pkack = 0;
  int  first_src = 0;
  int  samp_at_reply_end = 0;
  int  pk_at_reply_start = 0;
  bit  prev_busy = 0;
  int  gaps[$];
  int  pk_vals[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive();
    sample_rdy     = (sq.size() > 0);
    sample         = (sq.size() > 0) ? sq[0] : 8'h00;
    reply_rdy      = (rq.size() > 0);
    reply          = (rq.size() > 0) ? rq[0][7:0] : 8'h00;
    reply_end      = (rq.size() > 0) ? rq[0][8] : 1'b0;
    out_ack        = (int'($urandom_range(99)) < ack_pct);
    out_pktend_ack = (int'($urandom_range(99)) < pk_pct);
  endtask

  task automatic monitor();
    logic last;
    if (reset) begin
      chk("rst_out_rdy", {31'd0, out_rdy}, 0);
      chk("rst_sample_ack", {31'd0, sample_ack}, 0);
      chk("rst_reply_ack", {31'd0, reply_ack}, 0);
      chk("rst_pktend", {31'd0, out_pktend}, 0);
      chk("rst_busy", {31'd0, busy}, 0);
      pos = 0; in_reply = 0; need_flush = 0; streak = 0; prev_busy = 0;
      return;
    end
    chk("pkt_cnt", 32'(dut.pkt_cnt_q), pos);
    chk("ack_exclusive", {31'd0, sample_ack & reply_ack}, 0);
    if (sample_ack || reply_ack) chk("ack_needs_xfer", {31'd0, out_rdy & out_ack}, 1);
    if (out_rdy && out_ack) chk("xfer_has_ack", {31'd0, sample_ack | reply_ack}, 1);
    if (!busy) chk("idle_quiet", {31'd0, out_rdy | out_pktend}, 0);
    if (sample_ack) begin
      if (sq.size() == 0) begin
        chk("sample_spurious", {31'd0, sample_ack}, 0);
      end else begin
        chk("sample_data", 32'(out_data), 32'(sq[0]));
        void'(sq.pop_front());
        chk("no_interleave", {31'd0, in_reply}, 0);
        chk("flush_before_xfer", {31'd0, need_flush}, 0);
        if (first_src == 0) first_src = 1;
        streak++;
        chk("burst_bound", {31'd0, streak <= BURST_LEN}, 1);
        n_samp++;
        pos = (pos + 1) % PKT_SIZE;
      end
    end
    if (reply_ack) begin
      if (rq.size() == 0) begin
        chk("reply_spurious", {31'd0, reply_ack}, 0);
      end else begin
        chk("reply_data", 32'(out_data), 32'(rq[0][7:0]));
        if (!in_reply) begin
          // A reply always begins at the start of a packet.
          chk("reply_start_aligned", pos, 0);
          pk_at_reply_start = n_pkack;
        end
        chk("flush_before_xfer", {31'd0, need_flush}, 0);
        last = rq[0][8];
        void'(rq.pop_front());
        if (first_src == 0) first_src = 2;
        streak = 0;
        n_rep++;
        pos = (pos + 1) % PKT_SIZE;
        in_reply = !last;
        if (last) begin
          samp_at_reply_end = n_samp;
          if (pos != 0) need_flush = 1;
        end
      end
    end
    if (out_pktend && out_pktend_ack) begin
      chk("pktend_nonempty", {31'd0, pos != 0}, 1);
      pk_vals.push_back(int'(dut.pkt_cnt_q));
      pos = 0;
      need_flush = 0;
      n_pkack++;
    end
    if (!busy) streak = 0;
    if (prev_busy && !busy) gaps.push_back(n_samp);
    prev_busy = busy;
  endtask

  task automatic tick();
    @(negedge fx2_clk);
    monitor();
    @(posedge fx2_clk);
    #1;
    drive();
  endtask

  task automatic drain(input string tag, input int limit);
    int n;
    n = 0;
    while ((sq.size() > 0 || rq.size() > 0 || busy) && n < limit) begin
      tick();
      n++;
    end
    chk({tag, "_drain_timeout"}, {31'd0, n < limit}, 1);
  endtask

  task automatic reset_dut();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    drive();
  endtask

  task automatic push_samples(input int n);
    for (int i = 0; i < n; i++) sq.push_back(8'($urandom));
  endtask

  task automatic push_reply(input int len);
    logic [8:0] w;
    for (int i = 0; i < len; i++) begin
      w = {(i == len - 1), 8'($urandom)};
      rq.push_back(w);
    end
  endtask

  initial begin
    int base, pk0, pv0, n, tot_s, tot_r, rbase;
    reset = 1'b1;
    sample = 8'h00; sample_rdy = 1'b0;
    reply = 8'h00; reply_rdy = 1'b0; reply_end = 1'b0;
    out_ack = 1'b0; out_pktend_ack = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    drive();
    tick();
    chk("post_reset_busy", {31'd0, busy}, 0);
    chk("post_reset_pkt_cnt", 32'(dut.pkt_cnt_q), 0);

    // 1: sample and reply ready together with an empty packet.
    first_src = 0;
    base = n_samp;
    push_samples(3);
    push_reply(4);
    drive();
    drain("t1", 300);
    chk("t1_reply_first", first_src, 2);
    chk("t1_no_sample_before_reply_end", samp_at_reply_end - base, 0);
    chk("t1_samples_done", n_samp - base, 3);

    // 2: 200-byte sample stream with continuous out_ack.
    reset_dut();
    ack_pct = 100;
    base = n_samp;
    gaps.delete();
    push_samples(200);
    drive();
    n = 0;
    while (n_samp - base < 200 && n < 400) begin tick(); n++; end
    chk("t2_timeout", {31'd0, n < 400}, 1);
    chk("t2_pkt_cnt", 32'(dut.pkt_cnt_q), 200);
    repeat (5) tick();
    chk("t2_sample_acks", n_samp - base, 200);
    chk("t2_gap_count", {31'd0, gaps.size() >= 3}, 1);
    for (int i = 0; i < 3; i++)
      if (i < gaps.size()) chk("t2_burst_gap", gaps[i] - base, 64 * (i + 1));

    // 3: reply behind 10 bytes of partial sample data.
    reset_dut();
    ack_pct = 100;
    base = n_samp;
    push_samples(10);
    drive();
    n = 0;
    while (n_samp - base < 10 && n < 100) begin tick(); n++; end
    chk("t3_samples_timeout", {31'd0, n < 100}, 1);
    pk0 = n_pkack;
    pv0 = pk_vals.size();
    rbase = n_rep;
    push_reply(5);
    drive();
    drain("t3", 300);
    chk("t3_pre_flush", pk_at_reply_start - pk0, 1);
    chk("t3_flush_count", n_pkack - pk0, 2);
    chk("t3_reply_bytes", n_rep - rbase, 5);
    if (pk_vals.size() >= pv0 + 2) begin
      chk("t3_pre_pkt_cnt", pk_vals[pv0], 10);
      chk("t3_post_pkt_cnt", pk_vals[pv0 + 1], 5);
    end
    chk("t3_pkt_cnt_end", 32'(dut.pkt_cnt_q), 0);

    // 4: reply filling a whole packet after the pre-reply flush.
    reset_dut();
    ack_pct = 100;
    base = n_samp;
    push_samples(500);
    drive();
    n = 0;
    while (n_samp - base < 500 && n < 1200) begin tick(); n++; end
    chk("t4_samples_timeout", {31'd0, n < 1200}, 1);
    pk0 = n_pkack;
    pv0 = pk_vals.size();
    push_reply(PKT_SIZE);
    drive();
    drain("t4", 3000);
    chk("t4_only_pre_flush", n_pkack - pk0, 1);
    if (pk_vals.size() > pv0) chk("t4_pre_pkt_cnt", pk_vals[pv0], 500);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t4_no_post", {31'd0, out_pktend}, 0);
      chk("t4_idle", {31'd0, busy}, 0);
    end
    chk("t4_pkt_cnt", 32'(dut.pkt_cnt_q), 0);

    // 5: idle flush; the delay is counted from the first idle cycle after the sample grant ends.
    reset_dut();
    pk_pct = 0;
    base = n_samp;
    push_samples(3);
    drive();
    n = 0;
    while (n_samp - base < 3 && n < 50) begin tick(); n++; end
    chk("t5_samples_timeout", {31'd0, n < 50}, 1);
    n = 0;
    while (busy && n < 10) begin tick(); n++; end
    chk("t5_idle_reached", {31'd0, busy}, 0);
    n = 0;
    while (!out_pktend && n < FLUSH_CYCLES + 10) begin tick(); n++; end
    chk("t5_flush_delay", n, FLUSH_CYCLES);
    chk("t5_pkt_cnt_before", 32'(dut.pkt_cnt_q), 3);
    pk_pct = 100;
    drive();
    tick();
    chk("t5_pkt_cnt_after", 32'(dut.pkt_cnt_q), 0);
    chk("t5_idle_after", {31'd0, busy}, 0);

    // 6: reset lands on the third reply byte.
    reset_dut();
    ack_pct = 100;
    pk_pct = 50;
    rbase = n_rep;
    push_reply(6);
    drive();
    n = 0;
    while (n_rep - rbase < 2 && n < 50) begin tick(); n++; end
    chk("t6_reply_timeout", {31'd0, n < 50}, 1);
    reset = 1'b1;
    @(negedge fx2_clk);
    chk("t6_out_rdy", {31'd0, out_rdy}, 0);
    chk("t6_reply_ack", {31'd0, reply_ack}, 0);
    monitor();
    @(posedge fx2_clk);
    #1;
    reset = 1'b0;
    rq.delete();
    drive();
    chk("t6_idle", {31'd0, busy}, 0);
    chk("t6_pkt_cnt", 32'(dut.pkt_cnt_q), 0);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("t6_no_pktend", {31'd0, out_pktend}, 0);
    end

    // Randomized mixed traffic with stalls on both handshakes.
    reset_dut();
    base = n_samp;
    rbase = n_rep;
    tot_s = 0;
    tot_r = 0;
    for (int it = 0; it < 25; it++) begin
      int ns, nr;
      ack_pct = int'($urandom_range(100, 30));
      pk_pct  = int'($urandom_range(100, 20));
      ns = int'($urandom_range(150, 0));
      push_samples(ns);
      tot_s += ns;
      drive();
      repeat ($urandom_range(30, 0)) tick();
      if ($urandom_range(1, 0) == 1) begin
        nr = int'($urandom_range(40, 1));
        push_reply(nr);
        tot_r += nr;
        drive();
      end
      drain("rand", 6000);
    end
    chk("rand_sample_total", n_samp - base, tot_s);
    chk("rand_reply_total", n_rep - rbase, tot_r);
    chk("rand_pkt_cnt", 32'(dut.pkt_cnt_q), pos);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
